spdif_tx: RTL
=============

SPDIF_TX -- requirements
Module: spdif_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per BMC half-cell (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port resetb  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  transmit enable.
REQ-005 SHALL have port s_left  input  24  left sample, two's complement.
REQ-006 SHALL have port s_right  input  24  right sample, two's complement.
REQ-007 SHALL have port s_valid  input  1  the stereo pair on s_left/s_right is valid.
REQ-008 SHALL have port s_ready  output  1  the holding register is empty.
REQ-009 SHALL have port cs_word  input  32  channel-status bits 0..31.
REQ-010 SHALL have port tx_out  output  1  BMC-encoded SPDIF line.
REQ-011 SHALL have port busy  output  1  high while not IDLE.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with no data.
REQ-013 SHALL have port block_start  output  1  one-cycle pulse when frame 0 of a block starts.

Function
REQ-014 SHALL accept a pair when s_valid && s_ready on a rising edge, storing both samples in a one-entry holding register.
- s_ready SHALL fall on the next cycle.
- s_ready SHALL rise on the cycle after the holding register is loaded into the shifter.
REQ-015 SHALL implement states IDLE, PREAMBLE and DATA:
- IDLE->PREAMBLE on the first edge with ena=1;
- PREAMBLE->DATA after slot 3;
- DATA->PREAMBLE after slot 31, unless the right subframe ended with ena=0, in which case DATA->IDLE.
REQ-016 SHALL hold every half-cell for exactly CLK_DIV cycles.
- A slot is 2 half-cells, a subframe is 32 slots, a frame is a left subframe then a right subframe.
- A frame SHALL therefore be 128*CLK_DIV cycles, with no gaps between frames.
REQ-017 SHALL build each subframe slot by slot:
- slots 0-3: preamble;
- slots 4-27: sample, LSB in slot 4;
- slot 28: V;
- slot 29: U=0;
- slot 30: C;
- slot 31: P, even parity over slots 4-31.
REQ-018 SHALL BMC-encode slots 4-31: toggle tx_out at the start of every slot, and toggle again at mid-slot when the bit is 1.
REQ-019 SHALL emit preambles as 8 half-cells, XOR-inverted when the line level before the preamble is 1:
- B=11101000 on left of frame 0;
- M=11100010 on other left subframes;
- W=11100100 on all right subframes.
REQ-020 SHALL keep a frame counter 0..191 that increments after each right subframe and wraps from 191 to 0; block_start SHALL pulse on the first cycle of every B preamble.
REQ-021 SHALL latch cs_word at the start of frame 0. C for frame n SHALL be latched bit n when n<32, and 0 for n>=32; the same C SHALL be used in both subframes.
REQ-022 SHALL, at the start of each left preamble, load the holding register into the shifter if it is full.
- If it is empty: send zero audio with V=1 in both subframes, and pulse underrun for 1 cycle.
- Otherwise V=0.
REQ-023 SHALL, when s_valid && s_ready occurs on the same edge as a load, accept the new pair after the load; no pair is lost or duplicated.
REQ-024 SHALL sample ena only at frame boundaries for stopping.
- A deassertion mid-frame completes the right subframe through slot 31.
- It then enters IDLE with frame counter = 0, tx_out held at its final level, and the holding register retained.
REQ-025 SHALL ignore changes to CLK_DIV-independent inputs (cs_word, samples) outside their latch or accept points.

Reset
REQ-026 SHALL, on resetb=0, asynchronously set:
- state=IDLE, tx_out=0, s_ready=1, busy=0, underrun=0, block_start=0;
- frame counter=0, holding register empty, shifter cleared, divider=0.
REQ-027 SHALL, on reset asserted mid-frame, abort immediately with no completion of the subframe; after release, the first frame is frame 0 with a B preamble.

Verification
REQ-028 SHALL cover reset: with resetb low, tx_out=0, s_ready=1 and busy=0; with resetb high and ena=0 for 1000 cycles, tx_out stays 0.
REQ-029 SHALL cover a single frame: CLK_DIV=4, cs_word=0, s_left=0x000001, s_right=0x800000 accepted, then ena=1.
- First 32 cycles decode to B=11101000.
- Left subframe: slot 4=1, slots 5-30=0, P=1.
- Right subframe: slot 27=1, P=1.
- underrun is never asserted.
REQ-030 SHALL cover underrun: ena=1 with s_valid never asserted. underrun pulses every 512 cycles, audio slots are all 0, V=1 in both subframes, and P=1.
REQ-031 SHALL cover block wrap: run 193 frames with cs_word=0x00000005.
- C=1 in frames 0 and 2 only.
- block_start pulses are 98304 cycles apart.
- Frame 192 uses a B preamble.
REQ-032 SHALL cover back-pressure: hold s_valid=1 with 3 distinct pairs.
- s_ready stays low between loads.
- Each pair is transmitted exactly once, in order, in consecutive frames.
REQ-033 SHALL cover ena drop and reset mid-frame:
- ena=0 at left slot 10: transmission ends after right slot 31, busy falls, and tx_out stays constant.
- resetb pulsed mid-subframe: tx_out is 0 immediately, and after release the stream restarts with B.

Source files
------------

// File: rtl/spdif_tx.sv
// rtl/spdif_tx.sv - SPDIF BMC transmitter with one-entry stereo holding register
//
// Ports:
//   clk, resetb          clock (rising edge) and asynchronous active-low reset
//   ena                  transmit enable, sampled at frame boundaries
//   s_left, s_right      24-bit two's-complement stereo pair
//   s_valid, s_ready     pair handshake into the holding register
//   cs_word              channel-status bits 0..31, latched at the start of frame 0
//   tx_out               BMC-encoded line
//   busy                 high while a frame is being sent
//   underrun             one-cycle pulse when a frame starts with no data
//   block_start          one-cycle pulse on the first cycle of a B preamble
module spdif_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        ena,
    input  logic [23:0] s_left,
    input  logic [23:0] s_right,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] cs_word,
    output logic        tx_out,
    output logic        busy,
    output logic        underrun,
    output logic        block_start
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;

    localparam logic [7:0] PRE_B    = 8'b11101000;
    localparam logic [7:0] PRE_M    = 8'b11100010;
    localparam logic [7:0] PRE_W    = 8'b11100100;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [1:0]  state;
    logic [7:0]  div_cnt;
    logic [5:0]  hc;          // half-cell index within the subframe (0..63)
    logic        sub;         // 0 = left subframe, 1 = right subframe
    logic [7:0]  frame;       // 0..191 within the channel-status block
    logic [7:0]  pre_pat;     // preamble of the current subframe, already level-adjusted
    logic [31:0] cs_lat;
    logic [23:0] hold_l;
    logic [23:0] hold_r;
    logic        hold_full;
    logic [23:0] shift_l;
    logic [23:0] shift_r;
    logic        shift_v;

    logic        hc_end;
    logic        sub_end;
    logic        start_left;
    logic        start_right;
    logic        go_idle;
    logic [7:0]  frame_nxt;
    logic [7:0]  start_pat;
    logic [5:0]  hc_nxt;
    logic [23:0] cur_sample;
    logic        cur_c;
    logic        cur_par;
    logic        cur_bit;
    logic [4:0]  data_idx;

    assign s_ready = !hold_full;
    assign busy    = (state != ST_IDLE);

    assign hc_end      = (state != ST_IDLE) && (div_cnt == DIV_LAST);
    assign sub_end     = hc_end && (hc == 6'd63);
    assign start_left  = ((state == ST_IDLE) && ena) || (sub_end && sub && ena);
    assign start_right = sub_end && !sub;
    assign go_idle     = sub_end && sub && !ena;
    assign hc_nxt      = hc + 6'd1;

    // Leaving IDLE always begins a new block; otherwise step the block counter.
    assign frame_nxt = (state == ST_IDLE) ? 8'd0 :
                       (frame == 8'd191)  ? 8'd0 : frame + 8'd1;

    assign start_pat = start_right ? PRE_W :
                       (frame_nxt == 8'd0) ? PRE_B : PRE_M;

    assign cur_sample = sub ? shift_r : shift_l;
    assign cur_c      = (frame < 8'd32) ? cs_lat[frame[4:0]] : 1'b0;
    // U is always 0, so it does not contribute to the parity.
    assign cur_par    = ^{cur_sample, shift_v, cur_c};
    assign data_idx   = hc[5:1] - 5'd4;

    always_comb begin
        cur_bit = 1'b0;
        if (data_idx < 5'd24) begin
            cur_bit = cur_sample[data_idx];
        end else begin
            case (data_idx)
                5'd24:   cur_bit = shift_v;
                5'd26:   cur_bit = cur_c;
                5'd27:   cur_bit = cur_par;
                default: cur_bit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state       <= ST_IDLE;
            div_cnt     <= 8'd0;
            hc          <= 6'd0;
            sub         <= 1'b0;
            frame       <= 8'd0;
            pre_pat     <= 8'd0;
            cs_lat      <= 32'd0;
            hold_l      <= 24'd0;
            hold_r      <= 24'd0;
            hold_full   <= 1'b0;
            shift_l     <= 24'd0;
            shift_r     <= 24'd0;
            shift_v     <= 1'b0;
            tx_out      <= 1'b0;
            underrun    <= 1'b0;
            block_start <= 1'b0;
        end else begin
            underrun    <= 1'b0;
            block_start <= 1'b0;

            if (start_left || start_right) begin
                state   <= ST_PREAMBLE;
                div_cnt <= 8'd0;
                hc      <= 6'd0;
                sub     <= start_right;
                // Preamble is inverted when the line currently sits high.
                pre_pat <= start_pat ^ {8{tx_out}};
                tx_out  <= start_pat[7] ^ tx_out;
                if (start_left) begin
                    frame <= frame_nxt;
                    if (frame_nxt == 8'd0) begin
                        cs_lat      <= cs_word;
                        block_start <= 1'b1;
                    end
                    if (hold_full) begin
                        shift_l   <= hold_l;
                        shift_r   <= hold_r;
                        shift_v   <= 1'b0;
                        hold_full <= 1'b0;
                    end else begin
                        shift_l  <= 24'd0;
                        shift_r  <= 24'd0;
                        shift_v  <= 1'b1;
                        underrun <= 1'b1;
                    end
                end
            end else if (go_idle) begin
                state   <= ST_IDLE;
                frame   <= 8'd0;
                div_cnt <= 8'd0;
                hc      <= 6'd0;
                sub     <= 1'b0;
            end else if (hc_end) begin
                div_cnt <= 8'd0;
                hc      <= hc_nxt;
                if (hc == 6'd7) begin
                    state <= ST_DATA;
                end
                if (hc_nxt < 6'd8) begin
                    tx_out <= pre_pat[3'd7 - hc_nxt[2:0]];
                end else if (!hc_nxt[0]) begin
                    tx_out <= ~tx_out;           // slot boundary
                end else if (cur_bit) begin
                    tx_out <= ~tx_out;           // mid-slot toggle for a 1
                end
            end else if (state != ST_IDLE) begin
                div_cnt <= div_cnt + 8'd1;
            end

            // Accept only when empty, so this never collides with a load;
            // a pair offered at a load edge simply lands after the load.
            if (s_valid && !hold_full) begin
                hold_l    <= s_left;
                hold_r    <= s_right;
                hold_full <= 1'b1;
            end
        end
    end

endmodule
